// File: rtl/irrigation_timer_loader.sv
// irrigation_timer_loader: picks a watering duration, loads it into the BCD
// MM:SS countdown timer via per-bit preset/clear lines, then drives the valve
// and the timer's 1 Hz count clock while it runs, followed by a cooldown.
//
// state | meaning
// IDLE  | waiting for start pulse or auto soil-dry trigger
// LOAD  | preset/clear pattern for the captured duration held on the lines
// ARM   | lines released, waiting for the timer to report non-zero
// RUN   | valve open, sec_clk toggling, waiting for timer_zero
// HOLD  | cooldown of HOLDOFF_S seconds before the next cycle is accepted
// ABORT | all clear lines high to zero the timer after a stop
module irrigation_timer_loader #(
  parameter int CLK_HZ      = 50000000,
  parameter int SCAN_DIV    = 50000,
  parameter int LOAD_CYCLES = 4,
  parameter int HOLDOFF_S   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       soil_dry,
  input  logic       auto_en,
  input  logic [1:0] dur_sel,
  input  logic       timer_zero,
  output logic [3:0] preset_us,
  output logic [3:0] preset_ds,
  output logic [3:0] preset_um,
  output logic [3:0] preset_dm,
  output logic [3:0] clear_us,
  output logic [3:0] clear_ds,
  output logic [3:0] clear_um,
  output logic [3:0] clear_dm,
  output logic       sec_clk,
  output logic [1:0] seletor,
  output logic       valve,
  output logic       busy
);

  localparam int HALF = CLK_HZ / 2;
  localparam int PW   = $clog2(CLK_HZ);
  localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW   = (HOLDOFF_S > 1) ? $clog2(HOLDOFF_S) : 1;
  localparam int CW   = $clog2(LOAD_CYCLES + 8);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, HOLD, ABORT} state_t;

  state_t state, state_next;

  logic start_m, start_s, start_d;
  logic stop_m, stop_s;
  logic soil_m, soil_s;
  logic tz_m, tz_s;
  logic start_p, trigger;

  logic [PW-1:0] pre;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] step_cnt;
  logic [SW-1:0] scan_cnt;
  logic [15:0]   dig;      // {dm, um, ds, us} captured at trigger
  logic [15:0]   dig_sel;

  assign start_p = start_s & ~start_d;
  assign trigger = start_p | (auto_en & soil_s);
  assign busy    = (state != IDLE);
  assign valve   = (state == RUN);

  // BCD digits for each duration choice
  always_comb begin
    dig_sel = 16'h0030;
    case (dur_sel)
      2'b00: dig_sel = 16'h0030;
      2'b01: dig_sel = 16'h0100;
      2'b10: dig_sel = 16'h0500;
      2'b11: dig_sel = 16'h1000;
      default: dig_sel = 16'h0030;
    endcase
  end

  // Two-flop synchronisers plus the start edge detector delay flop
  always_ff @(posedge clk) begin
    if (rst) begin
      {start_m, start_s, start_d} <= 3'b000;
      {stop_m, stop_s}            <= 2'b00;
      {soil_m, soil_s}            <= 2'b00;
      {tz_m, tz_s}                <= 2'b00;
    end else begin
      start_m <= start;  start_s <= start_m;  start_d <= start_s;
      stop_m  <= stop;   stop_s  <= stop_m;
      soil_m  <= soil_dry; soil_s <= soil_m;
      tz_m    <= timer_zero; tz_s <= tz_m;
    end
  end

  // State register and duration capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dig   <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == IDLE && trigger) dig <= dig_sel;
    end
  end

  // Next-state logic; stop beats timer_zero beats trigger
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (trigger) state_next = LOAD;
      LOAD: begin
        if (stop_s) state_next = ABORT;
        else if (step_cnt == CW'(LOAD_CYCLES - 1)) state_next = ARM;
      end
      ARM: begin
        if (stop_s) state_next = ABORT;
        else if (!tz_s) state_next = RUN;
        else if (step_cnt == CW'(7)) state_next = IDLE;
      end
      RUN: begin
        if (stop_s) state_next = ABORT;
        else if (tz_s) state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HW'(HOLDOFF_S - 1) && pre == PW'(CLK_HZ - 1))
          state_next = IDLE;
      end
      ABORT: if (step_cnt == CW'(LOAD_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Preset/clear lines: duration pattern in LOAD, all-clear in ABORT
  always_comb begin
    {preset_dm, preset_um, preset_ds, preset_us} = 16'h0000;
    {clear_dm, clear_um, clear_ds, clear_us}     = 16'h0000;
    if (state == LOAD) begin
      {preset_dm, preset_um, preset_ds, preset_us} = dig;
      {clear_dm, clear_um, clear_ds, clear_us}     = ~dig;
    end else if (state == ABORT) begin
      {clear_dm, clear_um, clear_ds, clear_us}     = 16'hFFFF;
    end
  end

  // Per-state cycle counter for LOAD, ARM and ABORT; restarts on every state change
  always_ff @(posedge clk) begin
    if (rst || state_next != state) step_cnt <= '0;
    else if (state == LOAD || state == ARM || state == ABORT) step_cnt <= step_cnt + 1'b1;
  end

  // Prescaler: half-second wrap in RUN, full-second wrap in HOLD
  always_ff @(posedge clk) begin
    if (rst || state_next != state) pre <= '0;
    else if (state == RUN) pre <= (pre == PW'(HALF - 1)) ? '0 : pre + 1'b1;
    else if (state == HOLD) pre <= (pre == PW'(CLK_HZ - 1)) ? '0 : pre + 1'b1;
    else pre <= '0;
  end

  // Cooldown seconds counter
  always_ff @(posedge clk) begin
    if (rst || state_next != state) hold_cnt <= '0;
    else if (state == HOLD && pre == PW'(CLK_HZ - 1)) hold_cnt <= hold_cnt + 1'b1;
  end

  // Count clock: toggles only while staying in RUN, forced low otherwise
  always_ff @(posedge clk) begin
    if (rst) sec_clk <= 1'b0;
    else if (state == RUN && state_next == RUN) begin
      if (pre == PW'(HALF - 1)) sec_clk <= ~sec_clk;
    end else sec_clk <= 1'b0;
  end

  // Free-running display digit selector
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      seletor  <= 2'b00;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      seletor  <= seletor + 2'b01;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_irrigation_timer_loader.sv
// Testbench for irrigation_timer_loader with a behavioural BCD countdown timer.
module tb_irrigation_timer_loader;

  logic       clk = 1'b0;
  logic       rst, start, stop, soil_dry, auto_en;
  logic [1:0] dur_sel;
  logic       timer_zero;
  logic [3:0] preset_us, preset_ds, preset_um, preset_dm;
  logic [3:0] clear_us, clear_ds, clear_um, clear_dm;
  logic       sec_clk, valve, busy;
  logic [1:0] seletor;

  int checks = 0;
  int errors = 0;
  logic ignore_load = 1'b0;

  irrigation_timer_loader #(
    .CLK_HZ(8), .SCAN_DIV(2), .LOAD_CYCLES(4), .HOLDOFF_S(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .soil_dry(soil_dry),
    .auto_en(auto_en), .dur_sel(dur_sel), .timer_zero(timer_zero),
    .preset_us(preset_us), .preset_ds(preset_ds), .preset_um(preset_um), .preset_dm(preset_dm),
    .clear_us(clear_us), .clear_ds(clear_ds), .clear_um(clear_um), .clear_dm(clear_dm),
    .sec_clk(sec_clk), .seletor(seletor), .valve(valve), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model BCD MM:SS countdown timer
  logic [3:0] t_us = 4'd0, t_ds = 4'd0, t_um = 4'd0, t_dm = 4'd0;
  logic       sec_prev = 1'b0;
  logic       any_line;
  assign any_line   = |{preset_us, preset_ds, preset_um, preset_dm, clear_us, clear_ds, clear_um, clear_dm};
  assign timer_zero = (t_us == 0) && (t_ds == 0) && (t_um == 0) && (t_dm == 0);

  always @(posedge clk) begin
    sec_prev <= sec_clk;
    if (any_line && !ignore_load) begin
      t_us <= (t_us | preset_us) & ~clear_us;
      t_ds <= (t_ds | preset_ds) & ~clear_ds;
      t_um <= (t_um | preset_um) & ~clear_um;
      t_dm <= (t_dm | preset_dm) & ~clear_dm;
    end else if (sec_clk && !sec_prev && !timer_zero) begin
      if (t_us != 0) t_us <= t_us - 1;
      else begin
        t_us <= 4'd9;
        if (t_ds != 0) t_ds <= t_ds - 1;
        else begin
          t_ds <= 4'd5;
          if (t_um != 0) t_um <= t_um - 1;
          else begin
            t_um <= 4'd9;
            t_dm <= t_dm - 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; soil_dry = 0; auto_en = 0; dur_sel = 2'b01;
    repeat (3) tick();
    checks++;
    if ({preset_us, preset_ds, preset_um, preset_dm} !== 16'h0) begin
      errors++; $display("FAIL reset_presets got %h want 0000", {preset_us, preset_ds, preset_um, preset_dm});
    end
    checks++;
    if ({clear_us, clear_ds, clear_um, clear_dm} !== 16'h0) begin
      errors++; $display("FAIL reset_clears got %h want 0000", {clear_us, clear_ds, clear_um, clear_dm});
    end
    checks++;
    if ({sec_clk, valve, busy, seletor} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {sec_clk, valve, busy, seletor});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_load_run();
    int n, a, b, bad;
    dur_sel = 2'b01;
    start = 1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    start = 0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL trigger_latency got %0d want 3", n); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (preset_um !== 4'b0001 || clear_um !== 4'b1110 ||
          {preset_us, preset_ds, preset_dm} !== 12'h000 ||
          {clear_us, clear_ds, clear_dm} !== 12'hFFF) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL load_pattern_01 got %0d bad cycles want 0", bad); end
    checks++;
    if (any_line !== 1'b0) begin errors++; $display("FAIL load_release got %b want 0", any_line); end
    n = 0;
    while (!valve && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL arm_to_run got %0d want 1", n); end
    checks++;
    if (sec_clk !== 1'b0) begin errors++; $display("FAIL sec_clk_entry got %b want 0", sec_clk); end
    n = 0;
    while (!sec_clk && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL sec_clk_first_rise got %0d want 4", n); end
    a = 0;
    while (sec_clk && a < 20) begin tick(); a++; end
    b = 0;
    while (!sec_clk && b < 20) begin tick(); b++; end
    checks++;
    if (a + b !== 8 || a !== 4) begin errors++; $display("FAIL sec_clk_period got high %0d low %0d want 4 4", a, b); end
  endtask

  task automatic test_stop_abort();
    int bad;
    stop = 1;
    tick(); tick();
    checks++;
    if (valve !== 1'b1) begin errors++; $display("FAIL stop_valve_before got %b want 1", valve); end
    tick();
    checks++;
    if (valve !== 1'b0) begin errors++; $display("FAIL stop_valve_after got %b want 0", valve); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if ({clear_us, clear_ds, clear_um, clear_dm} !== 16'hFFFF ||
          {preset_us, preset_ds, preset_um, preset_dm} !== 16'h0000 || valve !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_clears got %0d bad cycles want 0", bad); end
    stop = 0;
    checks++;
    if (busy !== 1'b0 || any_line !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %b lines %b want 0 0", busy, any_line); end
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_no_hold got %b want 0", busy); end
  endtask

  task automatic test_run_to_zero();
    int n, rises, h;
    logic prev;
    dur_sel = 2'b11;
    start = 1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    start = 0;
    checks++;
    if (preset_dm !== 4'b0001 || clear_dm !== 4'b1110) begin
      errors++; $display("FAIL load_dm got preset %b clear %b want 0001 1110", preset_dm, clear_dm);
    end
    checks++;
    if ({preset_us, preset_ds, preset_um} !== 12'h000 || {clear_us, clear_ds, clear_um} !== 12'hFFF) begin
      errors++; $display("FAIL load_11_others got %h %h want 000 fff", {preset_us, preset_ds, preset_um}, {clear_us, clear_ds, clear_um});
    end
    n = 0;
    while (!valve && n < 20) begin tick(); n++; end
    rises = 0; prev = sec_clk; n = 0;
    while (valve && n < 6000) begin
      tick();
      if (sec_clk && !prev) rises++;
      prev = sec_clk;
      n++;
    end
    checks++;
    if (rises !== 600) begin errors++; $display("FAIL run_rises got %0d want 600", rises); end
    checks++;
    if (sec_clk !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_entry got sec %b busy %b want 0 1", sec_clk, busy); end
    h = 0;
    while (busy && h < 40) begin h++; tick(); end
    checks++;
    if (h !== 16) begin errors++; $display("FAIL hold_length got %0d want 16", h); end
  endtask

  task automatic test_auto();
    int n, h, g, bad;
    dur_sel = 2'b00; soil_dry = 1; auto_en = 1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    checks++;
    if (preset_ds !== 4'b0011 || clear_ds !== 4'b1100) begin
      errors++; $display("FAIL auto_load_ds got preset %b clear %b want 0011 1100", preset_ds, clear_ds);
    end
    n = 0;
    while (!valve && n < 20) begin tick(); n++; end
    n = 0;
    while (valve && n < 400) begin tick(); n++; end
    h = 0;
    while (busy && h < 40) begin h++; tick(); end
    checks++;
    if (h !== 16) begin errors++; $display("FAIL auto_hold got %0d want 16", h); end
    g = 0;
    while (!busy && g < 10) begin g++; tick(); end
    checks++;
    if (g !== 1) begin errors++; $display("FAIL auto_gap got %0d want 1", g); end
    checks++;
    if (preset_ds !== 4'b0011) begin errors++; $display("FAIL auto_second_load got %b want 0011", preset_ds); end
    auto_en = 0; stop = 1;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    stop = 0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (busy) bad++; end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL auto_disabled got %0d busy cycles want 0", bad); end
    soil_dry = 0;
  endtask

  task automatic test_arm_timeout();
    int n, b;
    logic seen;
    ignore_load = 1; dur_sel = 2'b01; start = 1;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    start = 0;
    b = 0; seen = 0;
    while (busy && b < 40) begin b++; if (valve) seen = 1; tick(); end
    checks++;
    if (b !== 12) begin errors++; $display("FAIL arm_timeout_len got %0d want 12", b); end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL arm_timeout_valve got %b want 0", seen); end
    ignore_load = 0;
  endtask

  task automatic test_seletor();
    int e;
    rst = 1;
    tick(); tick();
    rst = 0; start = 1; dur_sel = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = (k / 2) % 4;
      checks++;
      if (seletor !== 2'(e)) begin errors++; $display("FAIL seletor_step%0d got %b want %0d", k, seletor, e); end
    end
    start = 0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    n = 0;
    while (!valve && n < 40) begin tick(); n++; end
    n = 0;
    while (!sec_clk && n < 20) begin tick(); n++; end
    checks++;
    if (valve !== 1'b1 || sec_clk !== 1'b1) begin errors++; $display("FAIL mid_run_setup got valve %b sec %b want 1 1", valve, sec_clk); end
    rst = 1;
    tick();
    checks++;
    if ({sec_clk, valve, busy, seletor} !== 5'b0 || any_line !== 1'b0) begin
      errors++; $display("FAIL mid_run_reset got %b lines %b want 00000 0", {sec_clk, valve, busy, seletor}, any_line);
    end
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_stop_abort();
    test_run_to_zero();
    test_auto();
    test_arm_timeout();
    test_seletor();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_timer_loader.md
# irrigation_timer_loader

Control stage directly upstream of the BCD MM:SS countdown timer in the automated-irrigation design. It selects a watering duration and loads it into the timer's four digits through their per-bit preset/clear lines. It then generates the timer's 1 Hz count clock and the display digit-scan selector, drives the valve while the countdown runs, and enforces a cooldown before the next cycle.

## Interface
Parameters:
- CLK_HZ, 50000000, system clock frequency; must be even and ≥ 4.
- SCAN_DIV, 50000, clk cycles per display-selector step.
- LOAD_CYCLES, 4, cycles the preset/clear pattern is held.
- HOLDOFF_S, 10, cooldown seconds after a completed cycle.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  manual start button, asynchronous, level.
- stop  in  1  manual abort, asynchronous, level.
- soil_dry  in  1  moisture sensor, asynchronous, 1 = dry.
- auto_en  in  1  allows soil_dry to trigger a cycle.
- dur_sel  in  2  duration select: 00 = 00:30, 01 = 01:00, 10 = 05:00, 11 = 10:00.
- timer_zero  in  1  high when all four timer digits are 0; asynchronous.
- preset_us, preset_ds, preset_um, preset_dm  out  4 each  per-bit preset lines, active-high.
- clear_us, clear_ds, clear_um, clear_dm  out  4 each  per-bit clear lines, active-high.
- sec_clk  out  1  timer count clock.
- seletor  out  2  display digit-scan selector.
- valve  out  1  irrigation valve drive.
- busy  out  1  high in any state other than IDLE.

## Operation
- Input synchronisation:
  - start, stop, soil_dry and timer_zero each pass through a 2-flop synchroniser.
  - start is additionally rising-edge detected: start_p is a 1-cycle pulse.
- Trigger: start_p, or (auto_en && soil_dry_s). Triggers are accepted only in IDLE.
- Load pattern: the dur_sel BCD digits are captured at the trigger.
  - Digit bit = 1 → matching preset bit asserted.
  - Digit bit = 0 → matching clear bit asserted.
  - Preset and clear are never both high on the same bit.
- FSM states:
  - IDLE: all preset/clear low, valve 0, sec_clk 0.
    - Trigger → LOAD.
  - LOAD: pattern driven for LOAD_CYCLES cycles.
    - Then → ARM.
  - ARM: lines low.
    - !timer_zero_s → RUN.
    - After 8 cycles with timer_zero_s still high → IDLE (load failed, no valve pulse).
  - RUN: valve = 1, sec_clk toggles.
    - timer_zero_s → HOLD.
  - HOLD: valve 0, sec_clk held 0, counts HOLDOFF_S seconds using the internal prescaler.
    - Then → IDLE.
- Abort: stop_s in LOAD, ARM or RUN does all of the following:
  - forces all clear lines = 1111 and all preset lines = 0 for LOAD_CYCLES cycles, so the timer digits become 0;
  - valve 0 in the cycle after stop_s rises;
  - then → IDLE, with no cooldown.
  - stop_s in IDLE or HOLD has no effect.
- seletor: free-running 2-bit counter, incremented every SCAN_DIV cycles, wraps 3 → 0. It runs in every state.
- Priority within one cycle: rst > stop_s > timer_zero_s > trigger.

## Timing
- Reset values:
  - state IDLE;
  - all preset/clear 0, sec_clk 0, valve 0, busy 0, seletor 00;
  - prescaler 0, holdoff counter 0, synchronisers 0.
- Synchroniser latency: 2 cycles. An event seen at synchroniser output in cycle n changes state at edge n+1.
- Trigger to first load cycle: 1 cycle after the synchronised trigger.
- Load lines are high for exactly LOAD_CYCLES consecutive cycles.
- sec_clk:
  - The prescaler clears on entry to RUN; sec_clk = 0 on entry.
  - sec_clk toggles every CLK_HZ/2 cycles, so the first rising edge comes CLK_HZ/2 cycles after RUN entry and the period is CLK_HZ.
  - Leaving RUN forces sec_clk 0 on the next cycle.
- valve goes high on the first RUN cycle and low on the first non-RUN cycle.
- HOLD lasts exactly HOLDOFF_S·CLK_HZ cycles.
- Reset asserted mid-cycle (any state): outputs take reset values on the next edge. The timer digits are not touched.

## Test plan
Bench parameters: CLK_HZ=8, SCAN_DIV=2, LOAD_CYCLES=4, HOLDOFF_S=2. timer_zero is driven by a model timer.
- Reset, dur_sel=01, pulse start:
  - required: preset_um=0001, clear_um=1110, all other presets 0 and clears 1111, held 4 cycles;
  - then valve=1 and sec_clk period 8 cycles with the first rise 4 cycles after RUN entry.
- dur_sel=11, run to zero:
  - required: preset_dm=0001;
  - after 600 sec_clk rises timer_zero=1, valve drops, and busy stays 1 for 16 cycles (HOLD) then 0.
- stop asserted during RUN:
  - required: valve 0 one cycle after stop_s;
  - all clears 1111 for 4 cycles;
  - IDLE with no HOLD period.
- auto_en=1 with soil_dry held high:
  - required: back-to-back cycles separated by a 16-cycle HOLD;
  - with auto_en=0 no cycle starts.
- Model timer ignores the load (timer_zero stays 1):
  - required: ARM times out after 8 cycles, valve never high, return to IDLE.
- Free-run check:
  - required: seletor sequence 00,01,10,11,00 stepping every 2 cycles, unaffected by FSM activity;
  - reset mid-RUN returns all outputs to 0 next edge.
